dff_bank_arbiter: RTL
=====================

Name: dff_bank_arbiter

Overview:
Two-requester arbiter and sequencer for a bank of DEPTH words, each WIDTH d_flip_flop cells wide and sharing one d bus with a per-word st (store) enable. It grants the bank to one requester at a time using round-robin order. It drives the store enables and data bus for writes and returns registered read data. The block sits between CPU-side requesters and the flip-flop register bank in the memory subsystem.

Parameters:
WIDTH, 8, data width of each word in bits
DEPTH, 4, number of words in the bank
AW, 2, address width; must satisfy 2^AW >= DEPTH

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
req0  in  1  requester 0 transaction request
we0  in  1  requester 0 write (1) or read (0)
addr0  in  AW  requester 0 word address
wdata0  in  WIDTH  requester 0 write data
ack0  out  1  requester 0 completion pulse
rdata0  out  WIDTH  requester 0 read data, valid while ack0=1
req1, we1, addr1, wdata1, ack1, rdata1  same as requester 0, for requester 1
gnt  out  2  one-hot current owner; 00 when idle
st  out  DEPTH  per-word store enable to the bank
d  out  WIDTH  shared write-data bus to the bank
q  in  DEPTH*WIDTH  bank contents; word i occupies bits [i*WIDTH +: WIDTH]
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; gnt=00; st=0; d=0; ack0=ack1=0; rdata0=rdata1=0; busy=0.
  - Round-robin pointer set to "last served = 1", so requester 0 wins the first tie.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Every transaction takes exactly 3 cycles.
- IDLE:
  - Only req0 high: grant 0. Only req1 high: grant 1.
  - Both high: grant the requester not last served.
  - Neither high: stay in IDLE.
  - On a grant: latch the winner's we, addr and wdata into internal registers; set gnt; move to ACCESS.
- ACCESS (one cycle):
  - Write with latched addr < DEPTH: st = one-hot(addr), d = latched wdata. The bank captures on the edge that ends ACCESS.
  - Read: st=0; latched read word = q word[addr].
  - addr >= DEPTH: write is dropped (st=0); read returns 0.
  - Move to RESP.
- RESP (one cycle):
  - ack of the owner =1. Owner's rdata = latched read word for reads, 0 for writes.
  - Non-owner ack=0 and its rdata unchanged.
  - Update the pointer to the owner; gnt=00; move to IDLE.
- Latency: req sampled at edge k -> ACCESS during cycle k+1 -> ack during cycle k+2. Back-to-back transactions from the same requester start no earlier than cycle k+3.
- Requester contract: hold req, we, addr and wdata stable until ack. Drop req in the ack cycle unless issuing a new transaction. A req still high in IDLE counts as a new transaction.
- st is never asserted outside ACCESS and has at most one bit set. d holds its last value when st=0.
- Read-after-write to the same word from either requester returns the new data.
- rst_n low mid-transaction aborts it: no ack, no st pulse after reset, pointer reset.

Optional Feature:
DFF_BANK_LOCK_EN.
- Adds inputs lock0 and lock1 (1 bit each).
- When defined: if the owner's lock is high in RESP, gnt stays on that owner and the FSM returns to IDLE with only that requester eligible. This continues until the owner samples lock low in RESP, or its req is low in IDLE; the other requester's req is ignored in the meantime. Pointer update is suppressed while locked.
- When undefined: ports are absent and arbitration is plain round-robin.

Test Plan:
- Reset then write: req0=1, we0=1, addr0=2, wdata0=8'hA5 -> st=4'b0100 and d=A5 in cycle 1, ack0 in cycle 2, bank word2=A5.
- Read back: req1=1, we1=0, addr1=2 -> ack1 in cycle 2 with rdata1=A5; st stays 0 throughout.
- Tie after reset: req0=req1=1 at the same edge -> requester 0 served first (ack0), then requester 1 (ack1) exactly 3 cycles later; the next tie goes to requester 0 again.
- Out-of-range: DEPTH=3, write addr=3 with data 8'hFF -> ack given, st=0, no word changes; read addr=3 -> rdata=0.
- Reset mid-op: rst_n=0 during ACCESS of a write -> next cycle st=0, gnt=00, ack0=0, no further bank update; a subsequent tie is won by requester 0.
- DFF_BANK_LOCK_EN: lock0=1 with req0 and req1 both high over 3 transactions -> three consecutive ack0 pulses and no ack1; after lock0=0, the next grant goes to requester 1.

Source files
------------

// File: rtl/dff_bank_arbiter.sv
// Round-robin two-requester sequencer for a DEPTH x WIDTH flip-flop bank (IDLE -> ACCESS -> RESP).
// Define DFF_BANK_LOCK_EN to add lock0/lock1, which keep ownership with one requester across transactions.
module dff_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic                     we0,
    input  logic [AW-1:0]            addr0,
    input  logic [WIDTH-1:0]         wdata0,
    output logic                     ack0,
    output logic [WIDTH-1:0]         rdata0,
    input  logic                     req1,
    input  logic                     we1,
    input  logic [AW-1:0]            addr1,
    input  logic [WIDTH-1:0]         wdata1,
    output logic                     ack1,
    output logic [WIDTH-1:0]         rdata1,
`ifdef DFF_BANK_LOCK_EN
    input  logic                     lock0,
    input  logic                     lock1,
`endif
    output logic [1:0]               gnt,
    output logic [DEPTH-1:0]         st,
    output logic [WIDTH-1:0]         d,
    input  logic [DEPTH*WIDTH-1:0]   q,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               owner_reg;
    logic               last_reg;
    logic               locked_reg;
    logic               we_reg;
    logic [AW-1:0]      addr_reg;
    logic [WIDTH-1:0]   wdata_reg;
    logic [WIDTH-1:0]   d_reg;
    logic [1:0]         gnt_reg;
    logic [WIDTH-1:0]   rdata0_reg, rdata1_reg;

    logic               grant;
    logic               winner;
    logic               win_we;
    logic [AW-1:0]      win_addr;
    logic [WIDTH-1:0]   win_wdata;
    logic               owner_req;
    logic               owner_lock;
    logic [WIDTH-1:0]   rd_word;
    logic [WIDTH-1:0]   q_word [DEPTH];

`ifdef DFF_BANK_LOCK_EN
    assign owner_lock = owner_reg ? lock1 : lock0;
`else
    assign owner_lock = 1'b0;
`endif

    assign owner_req = owner_reg ? req1 : req0;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            assign q_word[gi] = q[gi*WIDTH +: WIDTH];
            // Out-of-range addresses match no bit, so such writes are dropped here.
            assign st[gi] = (state_reg == ACCESS) && we_reg && (addr_reg == AW'(gi));
        end
    endgenerate

    // Reads return zero for writes and for addresses beyond the bank.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!we_reg && (addr_reg == AW'(i))) begin
                rd_word = q_word[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        winner     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (locked_reg) begin
                    grant  = owner_req;
                    winner = owner_reg;
                end else if (req0 && (!req1 || last_reg)) begin
                    grant  = 1'b1;
                    winner = 1'b0;
                end else if (req1) begin
                    grant  = 1'b1;
                    winner = 1'b1;
                end
                if (grant) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        win_we    = winner ? we1    : we0;
        win_addr  = winner ? addr1  : addr0;
        win_wdata = winner ? wdata1 : wdata0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            owner_reg  <= 1'b0;
            last_reg   <= 1'b1;
            locked_reg <= 1'b0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            d_reg      <= '0;
            gnt_reg    <= 2'b00;
            rdata0_reg <= '0;
            rdata1_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        owner_reg <= winner;
                        we_reg    <= win_we;
                        addr_reg  <= win_addr;
                        wdata_reg <= win_wdata;
                        gnt_reg   <= winner ? 2'b10 : 2'b01;
                        // d only moves for writes that will actually strobe a word.
                        if (win_we && (int'(win_addr) < DEPTH)) begin
                            d_reg <= win_wdata;
                        end
                    end else if (locked_reg) begin
                        locked_reg <= 1'b0;
                        gnt_reg    <= 2'b00;
                    end
                end
                ACCESS: begin
                    if (owner_reg) begin
                        rdata1_reg <= rd_word;
                    end else begin
                        rdata0_reg <= rd_word;
                    end
                end
                RESP: begin
                    if (owner_lock) begin
                        locked_reg <= 1'b1;
                    end else begin
                        locked_reg <= 1'b0;
                        gnt_reg    <= 2'b00;
                        last_reg   <= owner_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt    = gnt_reg;
    assign d      = d_reg;
    assign busy   = (state_reg != IDLE);
    assign ack0   = (state_reg == RESP) && !owner_reg;
    assign ack1   = (state_reg == RESP) && owner_reg;
    assign rdata0 = rdata0_reg;
    assign rdata1 = rdata1_reg;

    // Keeps wdata_reg observable for anyone probing the latched transaction.
    logic unused_wdata;
    assign unused_wdata = ^wdata_reg;

endmodule
